// File: rtl/filtragem_pkg.sv
// Shared types and helpers for the sliding-window median filter.
// Provides slot_t (value, valid, age), size limits, age width and mid index.
package filtragem_pkg;

    localparam int MAX_DEPTH = 31;
    localparam int MAX_WIDTH = 16;

    function automatic int age_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    function automatic int mid_idx(input int depth);
        return (depth - 1) / 2;
    endfunction

    localparam int AGE_W = age_width(MAX_DEPTH);

    typedef struct packed {
        logic [MAX_WIDTH-1:0] value;
        logic                 valid;
        logic [AGE_W-1:0]     age;
    } slot_t;

    // Surviving slots get one step older; empty slots stay at age 0.
    function automatic slot_t aged(input slot_t s);
        slot_t r;
        r = s;
        if (s.valid)
            r.age = s.age + 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/celula_ordenada.sv
// One slot of the permanently sorted window.
// Ports: clk, rst, ena, flush, in_valid, new_value, below/above neighbour
// slots, gt_below/gt_above neighbour compares, del_here/del_below deletion
// flags (oldest slot at or below this one), slot (own state), gt (compare).
module celula_ordenada
    import filtragem_pkg::*;
#(
    parameter bit BASE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [MAX_WIDTH-1:0] new_value,
    input  slot_t                below,
    input  slot_t                above,
    input  logic                 gt_below,
    input  logic                 gt_above,
    input  logic                 del_here,
    input  logic                 del_below,
    output slot_t                slot,
    output logic                 gt
);

    logic  ins;
    logic  take_above;
    logic  take_below;
    slot_t fresh;

    // Empty slots rank above any value; strict compare puts new above ties.
    assign gt = !slot.valid || (new_value < slot.value);

    // Deletion below the insert point pulls slots down; otherwise push up.
    assign ins = (del_here && !gt && gt_above)
              || (!del_below && gt && !gt_below);
    assign take_above = del_here && !gt_above;
    assign take_below = gt_below && !del_below;

    always_comb begin
        fresh       = '0;
        fresh.value = new_value;
        fresh.valid = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else if (ena) begin
            if (flush) begin
                slot <= (BASE && in_valid) ? fresh : '0;
            end else if (in_valid) begin
                unique case (1'b1)
                    ins:        slot <= fresh;
                    take_above: slot <= aged(above);
                    take_below: slot <= aged(below);
                    default:    slot <= aged(slot);
                endcase
            end
        end
    end

endmodule

// File: rtl/filtro_mediana_janela.sv
// Streaming sliding-window median filter, one sample per clock.
// Ports: clk, rst, ena, flush, in_valid, in_data -> out_valid, out_median,
// fill_count; MEDIANA_MINMAX_EN adds out_min/out_max (window extremes).
module filtro_mediana_janela
    import filtragem_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_median,
`ifdef MEDIANA_MINMAX_EN
    output logic [WIDTH-1:0]           out_min,
    output logic [WIDTH-1:0]           out_max,
`endif
    output logic [$clog2(DEPTH+1)-1:0] fill_count
);

    localparam int FW  = $clog2(DEPTH + 1);
    localparam int MID = mid_idx(DEPTH);

    if (DEPTH < 3 || DEPTH > MAX_DEPTH || (DEPTH % 2) == 0) begin : g_bad_depth
        $error("filtro_mediana_janela: DEPTH must be odd, 3..31");
    end
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("filtro_mediana_janela: WIDTH must be 1..16");
    end

    // Index 0 and DEPTH+1 are fixed boundary entries around the real slots.
    slot_t                slot_x [DEPTH+2];
    logic                 gt_x   [DEPTH+2];
    logic [DEPTH:0]       del_x;
    logic                 full;
    logic                 pend;
    logic [MAX_WIDTH-1:0] new_value;

    assign full      = (fill_count == FW'(DEPTH));
    assign new_value = MAX_WIDTH'(in_data);

    assign slot_x[0]       = '0;
    assign slot_x[DEPTH+1] = '0;
    assign gt_x[0]         = 1'b0;
    assign gt_x[DEPTH+1]   = 1'b1;

    // Cumulative "oldest slot is at or below index" chain.
    always_comb begin
        del_x = '0;
        for (int i = 0; i < DEPTH; i++) begin
            del_x[i+1] = del_x[i]
                       || (full && slot_x[i+1].valid
                           && slot_x[i+1].age == AGE_W'(DEPTH - 1));
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        celula_ordenada #(
            .BASE (i == 0)
        ) u_cel (
            .clk       (clk),
            .rst       (rst),
            .ena       (ena),
            .flush     (flush),
            .in_valid  (in_valid),
            .new_value (new_value),
            .below     (slot_x[i]),
            .above     (slot_x[i+2]),
            .gt_below  (gt_x[i]),
            .gt_above  (gt_x[i+2]),
            .del_here  (del_x[i+1]),
            .del_below (del_x[i]),
            .slot      (slot_x[i+1]),
            .gt        (gt_x[i+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_count <= '0;
            pend       <= 1'b0;
        end else if (ena) begin
            pend <= in_valid && !flush
                 && (full || fill_count == FW'(DEPTH - 1));
            if (flush)
                fill_count <= in_valid ? FW'(1) : '0;
            else if (in_valid && !full)
                fill_count <= fill_count + 1'b1;
        end
    end

    // Output stage reads the array one edge after the update it reports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_median <= '0;
`ifdef MEDIANA_MINMAX_EN
            out_min    <= '0;
            out_max    <= '0;
`endif
        end else if (!ena) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= pend;
            if (pend) begin
                out_median <= slot_x[MID+1].value[WIDTH-1:0];
`ifdef MEDIANA_MINMAX_EN
                out_min    <= slot_x[1].value[WIDTH-1:0];
                out_max    <= slot_x[DEPTH].value[WIDTH-1:0];
`endif
            end
        end
    end

endmodule

// File: tb/tb_filtro_mediana_janela.sv
// Directed and model-checked bench for filtro_mediana_janela (DEPTH=9).
// Each cyc() drives one clock; outputs are sampled 1 time unit after it.
module tb_filtro_mediana_janela;

    localparam int W = 8;
    localparam int D = 9;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic [W-1:0] out_median;
`ifdef MEDIANA_MINMAX_EN
    logic [W-1:0] out_min;
    logic [W-1:0] out_max;
`endif
    logic [3:0]   fill_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    filtro_mediana_janela #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_median (out_median),
`ifdef MEDIANA_MINMAX_EN
        .out_min    (out_min),
        .out_max    (out_max),
`endif
        .fill_count (fill_count)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic f, input logic v,
                       input int d);
        ena      = e;
        flush    = f;
        in_valid = v;
        in_data  = W'(d);
        @(posedge clk);
        #1;
    endtask

    int nv;
    int hist[$];
    int srt[$];
    int exp_med;
    logic have_exp;

    initial begin
        rst = 1'b1; ena = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_median", out_median, 0);
        chk("rst_fill", fill_count, 0);
        rst = 1'b0;

        // ascending 0..8
        nv = 0;
        for (int i = 0; i < D; i++) begin
            cyc(1, 0, 1, i);
            nv += out_valid;
        end
        chk("asc_no_early_valid", nv, 0);
        chk("asc_fill", fill_count, 9);
        cyc(1, 0, 1, 100);
        chk("asc_valid", out_valid, 1);
        chk("asc_median", out_median, 4);
`ifdef MEDIANA_MINMAX_EN
        chk("asc_min", out_min, 0);
        chk("asc_max", out_max, 8);
`endif
        cyc(1, 0, 1, 0);
        chk("w100_median", out_median, 5);
        cyc(1, 0, 0, 0);
        chk("w0_valid", out_valid, 1);
        chk("w0_median", out_median, 5);
        cyc(1, 0, 0, 0);
        chk("idle_no_valid", out_valid, 0);

        // ties
        cyc(1, 1, 0, 0);
        chk("flush_fill", fill_count, 0);
        for (int i = 0; i < D; i++) cyc(1, 0, 1, 7);
        cyc(1, 0, 1, 7);
        chk("sevens_median", out_median, 7);
        cyc(1, 0, 1, 7);
        chk("tie7a", out_median, 7);
        cyc(1, 0, 1, 3);
        chk("tie7b", out_median, 7);
        for (int k = 1; k <= D; k++) begin
            cyc(1, 0, 1, 3);
            chk($sformatf("threes_%0d", k), out_median, (k >= 5) ? 3 : 7);
        end
        cyc(1, 0, 0, 0);
        chk("threes_final", out_median, 3);

        // descending after reset, then frozen cycles
        rst = 1'b1; #2; rst = 1'b0;
        for (int i = 8; i >= 0; i--) cyc(1, 0, 1, i);
        cyc(1, 0, 0, 0);
        chk("desc_valid", out_valid, 1);
        chk("desc_median", out_median, 4);
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 1, 255);
            nv += out_valid;
        end
        chk("ena0_no_valid", nv, 0);
        chk("ena0_fill", fill_count, 9);
        chk("ena0_median_hold", out_median, 4);
        cyc(1, 0, 1, 9);
        cyc(1, 0, 0, 0);
        chk("after9_valid", out_valid, 1);
        chk("after9_median", out_median, 4);

        // flush together with a sample
        cyc(1, 1, 1, 50);
        chk("flushv_fill", fill_count, 1);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 1, 10);
            nv += out_valid;
        end
        chk("flushv_no_early", nv, 0);
        chk("flushv_fill9", fill_count, 9);
        cyc(1, 0, 0, 0);
        chk("flushv_valid", out_valid, 1);
        chk("flushv_median", out_median, 10);

        // reset mid-stream
        cyc(1, 0, 1, 20);
        rst = 1'b1;
        #2;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_median", out_median, 0);
        chk("mrst_fill", fill_count, 0);
        rst = 1'b0;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 1, 200);
            nv += out_valid;
        end
        chk("mrst_refill_no_valid", nv, 0);
        chk("mrst_fill8", fill_count, 8);

        // random stream against a sorted reference window
        cyc(1, 1, 0, 0);
        hist.delete();
        have_exp = 1'b0;
        exp_med  = 0;
        for (int n = 0; n < 60; n++) begin
            int d;
            d = int'($urandom_range(0, 15));
            cyc(1, 0, 1, d);
            chk($sformatf("rnd_valid_%0d", n), out_valid, int'(have_exp));
            if (have_exp)
                chk($sformatf("rnd_med_%0d", n), out_median, exp_med);
            hist.push_back(d);
            if (hist.size() > D) void'(hist.pop_front());
            have_exp = (hist.size() == D);
            if (have_exp) begin
                srt = hist;
                srt.sort();
                exp_med = srt[(D - 1) / 2];
            end
        end
        cyc(1, 0, 0, 0);
        chk("rnd_last_median", out_median, exp_med);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
